// File: rtl/sop_pkg.sv
// rtl/sop_pkg.sv - shared types and defaults for the sop_feeder slice
// Purpose: default widths, the feeder state enum and the coefficient index type.
// Ports: none (package).
package sop_pkg;

  localparam int SIZE_2_DEF = 4;
  localparam int HOLD_DEF   = 4;
  // Hold counter width; covers the legal HOLD range 1..15.
  localparam int CNT_W      = 4;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [1:0] coef_idx_t;

endpackage

// File: rtl/sop_feeder_if.sv
// rtl/sop_feeder_if.sv - input word stream handshake for sop_feeder
// Purpose: groups the incoming word, its valid and the ready back-pressure.
// Ports: in_word (W bits), in_valid (producer to feeder), in_ready (feeder to producer).
// Modports: master = word producer, slave = sop_feeder.
interface sop_feeder_if #(
  parameter int W = 4
);

  logic [W-1:0] in_word;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_word,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/sop_hold_cnt.sv
// rtl/sop_hold_cnt.sv - loadable down-counter with zero flag
// Purpose: times how long a sample is held before the next one may be taken.
// Ports: clk, rst (async, active high), load/load_val (load takes priority),
//        count (current value), zero (count is 0).
module sop_hold_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sop_feeder.sv
// rtl/sop_feeder.sv - coefficient/sample feeder in front of the four-tap SOP
// Purpose: first four accepted words after reset or reload become C0..C3
//          (committed atomically); later words are samples driven on Data_in
//          and held for HOLD clocks.
// Ports: clk, rst (async, active high), in_s (word stream, slave side),
//        load_coef (reload request), Data_in (current sample),
//        C0..C3 (committed coefficients), out_valid (new-sample pulse),
//        coef_valid (a full set committed since reset).
module sop_feeder
  import sop_pkg::*;
#(
  parameter int SIZE_2 = SIZE_2_DEF,
  parameter int HOLD   = HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sop_feeder_if.slave       in_s,
  input  logic              load_coef,
  output logic [SIZE_2-1:0] Data_in,
  output logic [SIZE_2-1:0] C0,
  output logic [SIZE_2-1:0] C1,
  output logic [SIZE_2-1:0] C2,
  output logic [SIZE_2-1:0] C3,
  output logic              out_valid,
  output logic              coef_valid
);

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD - 1);

  state_t            state;
  coef_idx_t         idx;
  logic              pend_reload;
  logic [SIZE_2-1:0] shadow [3];

  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  logic              cnt_one;
  logic              accept;
  logic              cnt_load;

  // A reload request always blocks the word in the same cycle, so load_coef
  // wins over a simultaneous in_valid.
  assign in_s.in_ready = !rst && !load_coef &&
                         ((state == LOAD) || (cnt_zero && !pend_reload));

  assign accept   = in_s.in_valid && in_s.in_ready;
  assign cnt_load = accept && (state == RUN);
  assign cnt_one  = (cnt == CNT_W'(1));

  sop_hold_cnt #(
    .W (CNT_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (HOLD_RELOAD),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= '0;
      pend_reload <= 1'b0;
      shadow[0]   <= '0;
      shadow[1]   <= '0;
      shadow[2]   <= '0;
      C0          <= '0;
      C1          <= '0;
      C2          <= '0;
      C3          <= '0;
      Data_in     <= '0;
      out_valid   <= 1'b0;
      coef_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        LOAD: begin
          if (load_coef) begin
            // Restart collection; partially written shadows are simply overwritten.
            idx <= '0;
          end else if (accept) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: shadow[0] <= in_s.in_word;
              2'd1: shadow[1] <= in_s.in_word;
              2'd2: shadow[2] <= in_s.in_word;
              default: begin
                // Fourth word bypasses the shadow so all four land on one edge.
                C0         <= shadow[0];
                C1         <= shadow[1];
                C2         <= shadow[2];
                C3         <= in_s.in_word;
                coef_valid <= 1'b1;
                state      <= RUN;
              end
            endcase
          end
        end
        RUN: begin
          if (accept) begin
            Data_in   <= in_s.in_word;
            out_valid <= 1'b1;
          end else if (load_coef && cnt_zero) begin
            state <= LOAD;
            idx   <= '0;
          end else if ((load_coef || pend_reload) && cnt_one) begin
            // Hold expires on this edge: switch to LOAD as the counter hits 0.
            state       <= LOAD;
            idx         <= '0;
            pend_reload <= 1'b0;
          end else if (load_coef) begin
            pend_reload <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sop_feeder.sv
// tb/tb_sop_feeder.sv - self-checking bench for sop_feeder (HOLD=4 and HOLD=1)
module tb_sop_feeder;
  import sop_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;   // 0: HOLD=4 instance, 1: HOLD=1 instance
  logic       tv  = 1'b0;
  logic [3:0] tw  = 4'd0;
  logic       tlc = 1'b0;

  always #5 clk = ~clk;

  sop_feeder_if #(.W(4)) bus4 ();
  sop_feeder_if #(.W(4)) bus1 ();

  assign bus4.in_valid = tv & ~sel;
  assign bus4.in_word  = tw;
  assign bus1.in_valid = tv & sel;
  assign bus1.in_word  = tw;

  logic       lc4, lc1;
  assign lc4 = tlc & ~sel;
  assign lc1 = tlc & sel;

  logic [3:0] d4, d1;
  logic [3:0] c4 [4];
  logic [3:0] c1 [4];
  logic       ov4, ov1, cv4, cv1;

  sop_feeder #(.SIZE_2(4), .HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .in_s(bus4), .load_coef(lc4), .Data_in(d4),
    .C0(c4[0]), .C1(c4[1]), .C2(c4[2]), .C3(c4[3]),
    .out_valid(ov4), .coef_valid(cv4)
  );

  sop_feeder #(.SIZE_2(4), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_s(bus1), .load_coef(lc1), .Data_in(d1),
    .C0(c1[0]), .C1(c1[1]), .C2(c1[2]), .C3(c1[3]),
    .out_valid(ov1), .coef_valid(cv1)
  );

  wire [3:0]  o_data = sel ? d1 : d4;
  wire [15:0] o_coef = sel ? {c1[3], c1[2], c1[1], c1[0]} : {c4[3], c4[2], c4[1], c4[0]};
  wire        o_ov   = sel ? ov1 : ov4;
  wire        o_cv   = sel ? cv1 : cv4;
  wire        o_rdy  = sel ? bus1.in_ready : bus4.in_ready;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: described in terms of "collecting coefficients" vs
  // "streaming samples", words collected so far, and cycles left in the hold.
  int         m_h;
  bit         m_loading;
  logic [3:0] m_got [$];
  logic [3:0] m_c [4];
  bit         m_cv, m_ov, m_pend;
  logic [3:0] m_data;
  int         m_hold;

  function automatic logic [15:0] m_coef();
    return {m_c[3], m_c[2], m_c[1], m_c[0]};
  endfunction

  function automatic bit model_ready(input bit lc);
    return !lc && (m_loading || (m_hold == 0 && !m_pend));
  endfunction

  task automatic model_reset();
    m_h = sel ? 1 : 4;
    m_loading = 1'b1;
    m_got.delete();
    for (int i = 0; i < 4; i++) m_c[i] = 4'd0;
    m_cv = 1'b0; m_ov = 1'b0; m_pend = 1'b0; m_data = 4'd0; m_hold = 0;
  endtask

  task automatic model_edge(input bit v, input logic [3:0] w, input bit lc);
    bit acc;
    acc  = v && model_ready(lc);
    m_ov = 1'b0;
    if (m_loading) begin
      if (lc) m_got.delete();
      else if (acc) begin
        m_got.push_back(w);
        if (m_got.size() == 4) begin
          for (int i = 0; i < 4; i++) m_c[i] = m_got[i];
          m_got.delete();
          m_cv = 1'b1;
          m_loading = 1'b0;
        end
      end
    end else if (acc) begin
      m_data = w;
      m_ov   = 1'b1;
      m_hold = m_h - 1;
    end else if (m_hold == 0) begin
      if (lc) begin m_loading = 1'b1; m_got.delete(); end
    end else begin
      if ((lc || m_pend) && m_hold == 1) begin
        m_loading = 1'b1; m_pend = 1'b0; m_got.delete();
      end else if (lc) m_pend = 1'b1;
      m_hold = m_hold - 1;
    end
  endtask

  logic rdy_obs;
  bit   rdy_exp;

  // One clock: drive at edge+1, sample ready, advance model at the edge, settle to edge+1.
  task automatic step(input bit v, input logic [3:0] w, input bit lc);
    tv = v; tw = w; tlc = lc;
    #1;
    rdy_obs = o_rdy;
    rdy_exp = model_ready(lc);
    @(posedge clk);
    model_edge(v, w, lc);
    #1;
    tv = 1'b0; tlc = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tv = 1'b0; tlc = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; tv = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (o_data !== 4'd0) $display("FAIL reset_data got=%0d exp=0", o_data); else n_pass++;
    n_total++; if (o_coef !== 16'd0) $display("FAIL reset_coef got=%h exp=0000", o_coef); else n_pass++;
    n_total++; if (o_ov !== 1'b0 || o_cv !== 1'b0) $display("FAIL reset_flags ov=%b cv=%b exp=0/0", o_ov, o_cv); else n_pass++;
    n_total++; if (o_rdy !== 1'b0) $display("FAIL reset_ready got=%b exp=0", o_rdy); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (o_rdy !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", o_rdy); else n_pass++;
    tv = 1'b0;
    model_reset();
  endtask

  task automatic test_coef_load();
    logic [3:0] words [4];
    words = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0);
      if (i < 3) begin
        n_total++; if (o_coef !== 16'h0000 || o_cv !== 1'b0)
          $display("FAIL coef_partial_%0d coef=%h cv=%b exp=0000/0", i, o_coef, o_cv); else n_pass++;
      end
    end
    n_total++; if (o_coef !== 16'h4321) $display("FAIL coef_commit got=%h exp=4321", o_coef); else n_pass++;
    n_total++; if (o_cv !== 1'b1) $display("FAIL coef_valid got=%b exp=1", o_cv); else n_pass++;
  endtask

  task automatic test_hold();
    step(1'b1, 4'd5, 1'b0);
    n_total++; if (rdy_obs !== 1'b1) $display("FAIL hold_first_ready got=%b exp=1", rdy_obs); else n_pass++;
    n_total++; if (o_data !== 4'd5 || o_ov !== 1'b1)
      $display("FAIL hold_first_sample data=%0d ov=%b exp=5/1", o_data, o_ov); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'd6, 1'b0);
      n_total++; if (rdy_obs !== 1'b0 || o_ov !== 1'b0 || o_data !== 4'd5)
        $display("FAIL hold_wait_%0d rdy=%b ov=%b data=%0d exp=0/0/5", k, rdy_obs, o_ov, o_data); else n_pass++;
    end
    step(1'b1, 4'd6, 1'b0);
    n_total++; if (rdy_obs !== 1'b1 || o_data !== 4'd6 || o_ov !== 1'b1)
      $display("FAIL hold_second_sample rdy=%b data=%0d ov=%b exp=1/6/1", rdy_obs, o_data, o_ov); else n_pass++;
  endtask

  task automatic test_reload_mid_hold();
    logic [3:0] words [4];
    logic [15:0] expc;
    step(1'b1, 4'd9, 1'b1);
    n_total++; if (rdy_obs !== 1'b0) $display("FAIL reload_req_ready got=%b exp=0", rdy_obs); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'd9, 1'b0);
      n_total++; if (rdy_obs !== 1'b0 || o_data !== 4'd6 || o_coef !== 16'h4321)
        $display("FAIL reload_pending_%0d rdy=%b data=%0d coef=%h exp=0/6/4321", k, rdy_obs, o_data, o_coef); else n_pass++;
    end
    words = '{4'd4, 4'd5, 4'd6, 4'd7};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0);
      expc = (i < 3) ? 16'h4321 : 16'h7654;
      n_total++; if (rdy_obs !== 1'b1 || o_coef !== expc || o_data !== 4'd6)
        $display("FAIL reload_word_%0d rdy=%b coef=%h data=%0d exp=1/%h/6", i, rdy_obs, o_coef, o_data, expc); else n_pass++;
    end
  endtask

  task automatic test_reload_partial();
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    step(1'b1, 4'd2, 1'b1);
    n_total++; if (rdy_obs !== 1'b0 || o_coef !== 16'h7654)
      $display("FAIL partial_restart rdy=%b coef=%h exp=0/7654", rdy_obs, o_coef); else n_pass++;
    for (int i = 8; i < 12; i++) step(1'b1, 4'(i), 1'b0);
    n_total++; if (o_coef !== 16'hba98) $display("FAIL partial_commit got=%h exp=ba98", o_coef); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'd3, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd12, 1'b0);
    n_total++; if (o_data !== 4'd3 || o_coef !== 16'hba98)
      $display("FAIL mid_pre_state data=%0d coef=%h exp=3/ba98", o_data, o_coef); else n_pass++;
    rst = 1'b1; tv = 1'b1;
    #1;
    n_total++; if (o_data !== 4'd0 || o_coef !== 16'd0 || o_ov !== 1'b0 || o_cv !== 1'b0 || o_rdy !== 1'b0)
      $display("FAIL mid_reset data=%0d coef=%h ov=%b cv=%b rdy=%b exp=0", o_data, o_coef, o_ov, o_cv, o_rdy); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_total++; if (o_rdy !== 1'b1) $display("FAIL mid_release_ready got=%b exp=1", o_rdy); else n_pass++;
    tv = 1'b0;
  endtask

  task automatic test_hold1();
    logic [3:0] words [4];
    int prod;
    sel = 1'b1;
    do_reset();
    words = '{4'd2, 4'd1, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0);
    n_total++; if (o_coef !== 16'h4312) $display("FAIL h1_coef got=%h exp=4312", o_coef); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 4'(k), 1'b0);
      prod = int'(o_data) * (int'(o_coef[3:0]) + int'(o_coef[7:4]) + int'(o_coef[11:8]) + int'(o_coef[15:12]));
      n_total++; if (rdy_obs !== 1'b1 || o_ov !== 1'b1 || o_data !== 4'(k))
        $display("FAIL h1_stream_%0d rdy=%b ov=%b data=%0d exp=1/1/%0d", k, rdy_obs, o_ov, o_data, k); else n_pass++;
      n_total++; if (prod != k * 10) $display("FAIL h1_sop_%0d got=%0d exp=%0d", k, prod, k * 10); else n_pass++;
    end
    step(1'b0, 4'd0, 1'b0);
    n_total++; if (o_ov !== 1'b0 || o_data !== 4'd5)
      $display("FAIL h1_idle ov=%b data=%0d exp=0/5", o_ov, o_data); else n_pass++;
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int n = 0; n < 300; n++) begin
        step(($urandom % 4) != 0, 4'($urandom), ($urandom % 12) == 0);
        n_total++; if (rdy_obs !== rdy_exp)
          $display("FAIL rnd_ready s=%0d n=%0d got=%b exp=%b", s, n, rdy_obs, rdy_exp); else n_pass++;
        n_total++; if (o_data !== m_data || o_ov !== m_ov)
          $display("FAIL rnd_sample s=%0d n=%0d data=%0d ov=%b exp=%0d/%b", s, n, o_data, o_ov, m_data, m_ov); else n_pass++;
        n_total++; if (o_coef !== m_coef() || o_cv !== m_cv)
          $display("FAIL rnd_coef s=%0d n=%0d coef=%h cv=%b exp=%h/%b", s, n, o_coef, o_cv, m_coef(), m_cv); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_coef_load();
    test_hold();
    test_reload_mid_hold();
    test_reload_partial();
    test_reset_mid();
    test_hold1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
